// File: rtl/tank_ctl.sv
// Per-player tank motion: resolves direction keys once per frame (vsync rise) into
// sprite position and heading; outputs change one cycle after the vsync rise and hold for the frame.
module tank_ctl #(
  parameter int unsigned X_INIT = 376,
  parameter int unsigned Y_INIT = 268,
  parameter int unsigned X_MAX  = 752,
  parameter int unsigned Y_MAX  = 536,
  parameter int unsigned STEP   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        enable,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  output logic [11:0] posX,
  output logic [11:0] posY,
  output logic [1:0]  dir,
  output logic        moving
);

  localparam logic [1:0]  DIR_UP    = 2'd0;
  localparam logic [1:0]  DIR_DOWN  = 2'd1;
  localparam logic [1:0]  DIR_LEFT  = 2'd2;
  localparam logic [1:0]  DIR_RIGHT = 2'd3;

  localparam logic [11:0] X_INIT_W = 12'(X_INIT);
  localparam logic [11:0] Y_INIT_W = 12'(Y_INIT);
  localparam logic [11:0] X_MAX_W  = 12'(X_MAX);
  localparam logic [11:0] Y_MAX_W  = 12'(Y_MAX);
  localparam logic [11:0] STEP_W   = 12'(STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TURN = 2'd1,
    S_MOVE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        vsync_d;
  logic        tick;
  logic        key_vld;
  logic [1:0]  key_dir;
  logic [11:0] pos_x_nx;
  logic [11:0] pos_y_nx;
  logic [1:0]  dir_nx;

  function automatic logic [11:0] step_dec(input logic [11:0] p);
    return (p < STEP_W) ? 12'd0 : p - STEP_W;
  endfunction

  // Sum kept in 13 bits so a position near 4095 cannot wrap past the clamp.
  function automatic logic [11:0] step_inc(input logic [11:0] p, input logic [11:0] lim);
    logic [12:0] s;
    s = {1'b0, p} + {1'b0, STEP_W};
    return (s > {1'b0, lim}) ? lim : s[11:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) vsync_d <= 1'b0;
    else     vsync_d <= vsync_in;
  end

  assign tick = vsync_in & ~vsync_d;

  // Fixed priority up > down > left > right keeps motion on one axis.
  always_comb begin
    key_vld = 1'b1;
    key_dir = DIR_UP;
    if (key_up)         key_dir = DIR_UP;
    else if (key_down)  key_dir = DIR_DOWN;
    else if (key_left)  key_dir = DIR_LEFT;
    else if (key_right) key_dir = DIR_RIGHT;
    else                key_vld = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (tick) begin
      if (!enable || !key_vld) state_nx = S_IDLE;
      else if (key_dir == dir) state_nx = S_MOVE;
      else                     state_nx = S_TURN;
    end
  end

  always_comb begin
    pos_x_nx = posX;
    pos_y_nx = posY;
    dir_nx   = dir;
    if (tick && enable && key_vld) begin
      if (key_dir != dir) begin
        dir_nx = key_dir;
      end else begin
        case (key_dir)
          DIR_UP:    pos_y_nx = step_dec(posY);
          DIR_DOWN:  pos_y_nx = step_inc(posY, Y_MAX_W);
          DIR_LEFT:  pos_x_nx = step_dec(posX);
          default:   pos_x_nx = step_inc(posX, X_MAX_W);
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      posX   <= X_INIT_W;
      posY   <= Y_INIT_W;
      dir    <= DIR_UP;
      moving <= 1'b0;
    end else begin
      posX   <= pos_x_nx;
      posY   <= pos_y_nx;
      dir    <= dir_nx;
      moving <= (state_nx == S_MOVE);
    end
  end

endmodule
